// File: rtl/otp_ctrl_seq_if.sv
// Request/response handshake between the OTP controller front end and the eFuse pin sequencer.
interface otp_ctrl_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [6:0] req_addr;
  logic [2:0] req_bit;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  modport master (
    output req_valid, req_wr, req_addr, req_bit,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_bit,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/otp_ctrl_seq.sv
// eFuse (128x8) pin sequencer: counter-timed setup/strobe/hold for read-byte and program-bit.
// Optional OTP_CTRL_VERIFY_EN adds an automatic read-back after each program operation.
module otp_ctrl_seq #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_RD    = 4,
  parameter int unsigned T_PGM   = 20,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst_mode,
  otp_ctrl_seq_if.slave    bus,
  output logic             CSB,
  output logic             PGENB,
  output logic             LOAD,
  output logic             VDDQ,
  output logic             STROBE,
  output logic [9:0]       A,
  input  logic [7:0]       Q
);

  // Counter reload values: phase length minus one, a zero length behaves as one
  localparam logic [15:0] LD_SETUP = (T_SETUP == 0) ? 16'd0 : 16'(T_SETUP - 1);
  localparam logic [15:0] LD_RD    = (T_RD    == 0) ? 16'd0 : 16'(T_RD    - 1);
  localparam logic [15:0] LD_PGM   = (T_PGM   == 0) ? 16'd0 : 16'(T_PGM   - 1);
  localparam logic [15:0] LD_HOLD  = (T_HOLD  == 0) ? 16'd0 : 16'(T_HOLD  - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE
`ifdef OTP_CTRL_VERIFY_EN
    , S_GAP, S_VSETUP, S_VPULSE, S_VHOLD
`endif
  } state_t;

  state_t      state, nxt;
  logic [15:0] cnt;
  logic        phase_end;
  logic        op_wr;
  logic [6:0]  op_addr;
  logic [2:0]  op_bit;
  logic [7:0]  cap;
  logic        rd_last;
  logic        cur_wr;
  logic [6:0]  cur_addr;
  logic [2:0]  cur_bit;
  logic        csb_n, pgenb_n, load_n, vddq_n, strobe_n;
  logic [9:0]  a_n;
  logic [7:0]  rsp_data_q;

  function automatic logic [15:0] load_val(input state_t s, input logic wr);
    case (s)
      S_SETUP: load_val = LD_SETUP;
      S_PULSE: load_val = wr ? LD_PGM : LD_RD;
      S_HOLD:  load_val = LD_HOLD;
`ifdef OTP_CTRL_VERIFY_EN
      S_VSETUP: load_val = LD_SETUP;
      S_VPULSE: load_val = LD_RD;
      S_VHOLD:  load_val = LD_HOLD;
`endif
      default: load_val = '0;
    endcase
  endfunction

  assign phase_end = (cnt == '0);

  always_ff @(posedge clk or negedge rst_mode) begin
    if (!rst_mode) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      op_addr <= '0;
      op_bit  <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && nxt == S_SETUP) begin
        op_wr   <= bus.req_wr;
        op_addr <= bus.req_addr;
        op_bit  <= bus.req_bit;
      end
      if (nxt != state) cnt <= load_val(nxt, op_wr);
      else if (!phase_end) cnt <= cnt - 16'd1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.req_valid) nxt = S_SETUP;
      S_SETUP: if (phase_end) nxt = S_PULSE;
      S_PULSE: if (phase_end) nxt = S_HOLD;
`ifdef OTP_CTRL_VERIFY_EN
      S_HOLD:   if (phase_end) nxt = op_wr ? S_GAP : S_DONE;
      S_GAP:    nxt = S_VSETUP;
      S_VSETUP: if (phase_end) nxt = S_VPULSE;
      S_VPULSE: if (phase_end) nxt = S_VHOLD;
      S_VHOLD:  if (phase_end) nxt = S_DONE;
`else
      S_HOLD:  if (phase_end) nxt = S_DONE;
`endif
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Pins are decoded from the next state and registered, so on the accept edge
  // the request fields come straight from the bus rather than the latch.
  assign cur_wr   = (state == S_IDLE) ? bus.req_wr   : op_wr;
  assign cur_addr = (state == S_IDLE) ? bus.req_addr : op_addr;
  assign cur_bit  = (state == S_IDLE) ? bus.req_bit  : op_bit;

  always_comb begin
    csb_n    = 1'b1;
    pgenb_n  = 1'b1;
    load_n   = 1'b0;
    vddq_n   = 1'b0;
    strobe_n = 1'b0;
    a_n      = '0;
    case (nxt)
      S_SETUP, S_PULSE, S_HOLD: begin
        csb_n    = 1'b0;
        strobe_n = (nxt == S_PULSE);
        if (cur_wr) begin
          vddq_n  = 1'b1;
          pgenb_n = 1'b0;
          a_n     = {cur_bit, cur_addr};
        end else begin
          load_n = 1'b1;
          a_n    = {3'b000, cur_addr};
        end
      end
`ifdef OTP_CTRL_VERIFY_EN
      S_VSETUP, S_VPULSE, S_VHOLD: begin
        csb_n    = 1'b0;
        load_n   = 1'b1;
        strobe_n = (nxt == S_VPULSE);
        a_n      = {3'b000, op_addr};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_mode) begin
    if (!rst_mode) begin
      CSB    <= 1'b1;
      PGENB  <= 1'b1;
      LOAD   <= 1'b0;
      VDDQ   <= 1'b0;
      STROBE <= 1'b0;
      A      <= '0;
    end else begin
      CSB    <= csb_n;
      PGENB  <= pgenb_n;
      LOAD   <= load_n;
      VDDQ   <= vddq_n;
      STROBE <= strobe_n;
      A      <= a_n;
    end
  end

`ifdef OTP_CTRL_VERIFY_EN
  assign rd_last = phase_end && ((state == S_PULSE && !op_wr) || state == S_VPULSE);
`else
  assign rd_last = phase_end && state == S_PULSE && !op_wr;
`endif

  always_ff @(posedge clk or negedge rst_mode) begin
    if (!rst_mode) cap <= '0;
    else if (rd_last) cap <= Q;
  end

`ifdef OTP_CTRL_VERIFY_EN
  logic rsp_err_q;

  always_ff @(posedge clk or negedge rst_mode) begin
    if (!rst_mode) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (nxt == S_DONE && state != S_DONE) begin
      rsp_data_q <= cap;
      rsp_err_q  <= op_wr && !cap[op_bit];
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  always_ff @(posedge clk or negedge rst_mode) begin
    if (!rst_mode) rsp_data_q <= '0;
    else if (nxt == S_DONE && state != S_DONE) rsp_data_q <= op_wr ? 8'h00 : cap;
  end

  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_otp_ctrl_seq.sv
// Directed self-checking bench for otp_ctrl_seq (also covers OTP_CTRL_VERIFY_EN when defined).
module tb_otp_ctrl_seq;
  localparam int unsigned TS = 2;
  localparam int unsigned TR = 4;
  localparam int unsigned TP = 20;
  localparam int unsigned TH = 2;
  localparam int RD_LAT = 9;
`ifdef OTP_CTRL_VERIFY_EN
  localparam int PG_LAT  = TS + TP + TH + 1 + TS + TR + TH + 1;
  localparam int PG_STRB = TP + TR;
  localparam bit VER     = 1'b1;
`else
  localparam int PG_LAT  = 25;
  localparam int PG_STRB = TP;
  localparam bit VER     = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_mode = 1'b0;
  logic       CSB, PGENB, LOAD, VDDQ, STROBE;
  logic [9:0] A;
  logic [7:0] q = 8'h00;
  int         checks = 0;
  int         failures = 0;

  otp_ctrl_seq_if bus ();

  otp_ctrl_seq #(.T_SETUP(TS), .T_RD(TR), .T_PGM(TP), .T_HOLD(TH)) dut (
    .clk(clk), .rst_mode(rst_mode), .bus(bus),
    .CSB(CSB), .PGENB(PGENB), .LOAD(LOAD), .VDDQ(VDDQ), .STROBE(STROBE),
    .A(A), .Q(q)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [14:0] idle_pins, prev;
    int toggles;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_bit = '0;
    rst_mode = 1'b0;
    #12;
    checks++;
    if ({CSB, PGENB, LOAD, VDDQ, STROBE, A} !== {5'b11000, 10'h000}) begin
      failures++; $display("FAIL reset_pins got=%b exp=%b", {CSB, PGENB, LOAD, VDDQ, STROBE, A}, {5'b11000, 10'h000});
    end
    checks++;
    if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err} !== 4'b1000) begin
      failures++; $display("FAIL reset_status got=%b exp=1000", {bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_err});
    end
    checks++;
    if (bus.rsp_data !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", bus.rsp_data);
    end
    @(negedge clk); rst_mode = 1'b1;
    idle_pins = {CSB, PGENB, LOAD, VDDQ, STROBE, A};
    toggles = 0;
    for (int i = 0; i < 10; i++) begin
      prev = {CSB, PGENB, LOAD, VDDQ, STROBE, A};
      @(negedge clk);
      if ({CSB, PGENB, LOAD, VDDQ, STROBE, A} !== prev) toggles++;
    end
    checks++;
    if (toggles !== 0 || {CSB, PGENB, LOAD, VDDQ, STROBE, A} !== idle_pins) begin
      failures++; $display("FAIL idle_toggle got=%0d exp=0", toggles);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  // exp_mode = {CSB, PGENB, LOAD, VDDQ} seen in the first SETUP cycle
  task automatic run_op(input string name, input logic wr, input logic [6:0] addr, input logic [2:0] bitn,
                        input logic [7:0] qv, input logic [9:0] exp_a, input logic [3:0] exp_mode,
                        input int exp_strb, input int exp_lat, input logic [7:0] exp_data, input logic exp_err);
    int strb, first_rise, lat, viol;
    logic prev_strb;
    logic [13:0] prev_pins;
    logic [7:0] got_data;
    logic got_err;
    strb = 0; first_rise = 0; lat = 0; viol = 0; prev_strb = 1'b0; prev_pins = '0;
    got_data = 'x; got_err = 'x;
    @(negedge clk);
    bus.req_wr = wr; bus.req_addr = addr; bus.req_bit = bitn; bus.req_valid = 1'b1; q = qv;
    @(posedge clk);
    for (int c = 1; c <= exp_lat + 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        checks++;
        if ({CSB, PGENB, LOAD, VDDQ, A} !== {exp_mode, exp_a}) begin
          failures++; $display("FAIL %s_setup_pins got=%b_%h exp=%b_%h", name, {CSB, PGENB, LOAD, VDDQ}, A, exp_mode, exp_a);
        end
      end
      if (STROBE === 1'b1) begin
        strb++;
        if (first_rise == 0) first_rise = c;
        if (prev_strb && {CSB, PGENB, LOAD, VDDQ, A} !== prev_pins) viol++;
      end
      prev_strb = STROBE;
      prev_pins = {CSB, PGENB, LOAD, VDDQ, A};
      if (bus.rsp_valid === 1'b1 && lat == 0) begin
        lat = c; got_data = bus.rsp_data; got_err = bus.rsp_err;
      end
    end
    checks++;
    if (strb != exp_strb) begin
      failures++; $display("FAIL %s_strobe_width got=%0d exp=%0d", name, strb, exp_strb);
    end
    checks++;
    if (first_rise != int'(TS) + 1) begin
      failures++; $display("FAIL %s_strobe_rise got=%0d exp=%0d", name, first_rise, TS + 1);
    end
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL %s_pins_under_strobe got=%0d exp=0", name, viol);
    end
    checks++;
    if (lat != exp_lat) begin
      failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
    end
    checks++;
    if (got_data !== exp_data || got_err !== exp_err) begin
      failures++; $display("FAIL %s_rsp got=%h/%b exp=%h/%b", name, got_data, got_err, exp_data, exp_err);
    end
    checks++;
    if (bus.rsp_data !== exp_data || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL %s_hold_data got=%h/%b exp=%h/1", name, bus.rsp_data, bus.req_ready, exp_data);
    end
  endtask

  task automatic test_read();
    run_op("read2a", 1'b0, 7'h2A, 3'd0, 8'hA5, 10'h02A, 4'b0110, TR, RD_LAT, 8'hA5, 1'b0);
    run_op("read7f", 1'b0, 7'h7F, 3'd6, 8'h5A, 10'h07F, 4'b0110, TR, RD_LAT, 8'h5A, 1'b0);
  endtask

  task automatic test_program();
    run_op("prog05", 1'b1, 7'h05, 3'd3, 8'h08, 10'h185, 4'b0001, PG_STRB, PG_LAT, VER ? 8'h08 : 8'h00, 1'b0);
    run_op("prog7f", 1'b1, 7'h7F, 3'd7, 8'hFF, 10'h3FF, 4'b0001, PG_STRB, PG_LAT, VER ? 8'hFF : 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat2;
    logic [7:0] d2;
    lat2 = 0; d2 = 'x;
    @(negedge clk);
    bus.req_wr = 1'b0; bus.req_addr = 7'h2A; bus.req_bit = 3'd0; bus.req_valid = 1'b1; q = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    bus.req_wr = 1'b1; bus.req_addr = 7'h05; bus.req_bit = 3'd3;
    for (int c = 2; c <= 10 + PG_LAT + 3; c++) begin
      @(negedge clk);
      if (c == 9) begin
        checks++;
        if ({bus.rsp_valid, CSB, bus.req_ready, bus.rsp_data} !== {3'b110, 8'hA5}) begin
          failures++; $display("FAIL b2b_done got=%b_%h exp=110_a5", {bus.rsp_valid, CSB, bus.req_ready}, bus.rsp_data);
        end
      end
      if (c == 10) begin
        checks++;
        if ({bus.req_ready, bus.busy, CSB} !== 3'b101) begin
          failures++; $display("FAIL b2b_gap got=%b exp=101", {bus.req_ready, bus.busy, CSB});
        end
      end
      if (c == 11) begin
        checks++;
        if ({bus.busy, CSB, VDDQ, A} !== {3'b101, 10'h185}) begin
          failures++; $display("FAIL b2b_second_accept got=%b_%h exp=101_185", {bus.busy, CSB, VDDQ}, A);
        end
        bus.req_valid = 1'b0;
        q = 8'h08;
      end
      if (c > 11 && bus.rsp_valid === 1'b1 && lat2 == 0) begin
        lat2 = c; d2 = bus.rsp_data;
      end
    end
    checks++;
    if (lat2 != 10 + PG_LAT || d2 !== (VER ? 8'h08 : 8'h00)) begin
      failures++; $display("FAIL b2b_second_rsp got=%0d/%h exp=%0d/%h", lat2, d2, 10 + PG_LAT, VER ? 8'h08 : 8'h00);
    end
  endtask

  task automatic test_reset_mid_program();
    int rsp_cnt;
    rsp_cnt = 0;
    @(negedge clk);
    bus.req_wr = 1'b1; bus.req_addr = 7'h05; bus.req_bit = 3'd3; bus.req_valid = 1'b1; q = 8'h08;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    checks++;
    if ({STROBE, VDDQ} !== 2'b11) begin
      failures++; $display("FAIL midrst_pulse got=%b exp=11", {STROBE, VDDQ});
    end
    #2 rst_mode = 1'b0;
    #1;
    checks++;
    if ({STROBE, VDDQ, CSB, PGENB, A, bus.busy, bus.req_ready} !== {4'b0011, 10'h000, 2'b01}) begin
      failures++; $display("FAIL midrst_drop got=%b_%h_%b exp=0011_000_01", {STROBE, VDDQ, CSB, PGENB}, A, {bus.busy, bus.req_ready});
    end
    @(negedge clk); rst_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) rsp_cnt++;
    end
    checks++;
    if (rsp_cnt != 0) begin
      failures++; $display("FAIL midrst_no_rsp got=%0d exp=0", rsp_cnt);
    end
    run_op("read_after_rst", 1'b0, 7'h11, 3'd0, 8'h3C, 10'h011, 4'b0110, TR, RD_LAT, 8'h3C, 1'b0);
  endtask

`ifdef OTP_CTRL_VERIFY_EN
  task automatic test_verify_err();
    run_op("verify_err", 1'b1, 7'h00, 3'd0, 8'h00, 10'h000, 4'b0001, PG_STRB, PG_LAT, 8'h00, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_program();
    test_back_to_back();
    test_reset_mid_program();
`ifdef OTP_CTRL_VERIFY_EN
    test_verify_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
